// File: rtl/player_grid_ctl.sv
// rtl/player_grid_ctl.sv - 10x10 Warships board state store with click-driven updates (optional PLAYER_GRID_HIDE_SHIPS_EN)
module player_grid_ctl #(
    parameter int X_POS          = 100,
    parameter int Y_POS          = 100,
    parameter int CELL_SIZE      = 32,
    parameter int GRID_SIZE      = 10,
    parameter int MAX_SHIP_CELLS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic        mouse_left,
    input  logic        mode,
    input  logic        clear,
    input  logic [7:0]  grid_addr,
    output logic [1:0]  grid_status,
    output logic        busy,
    output logic [4:0]  ship_cells,
    output logic [4:0]  hit_cells,
    output logic        all_sunk
);
    localparam int DEPTH = GRID_SIZE * GRID_SIZE;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [11:0] X_LO      = 12'(X_POS);
    localparam logic [11:0] X_HI      = 12'(X_POS + GRID_SIZE * CELL_SIZE);
    localparam logic [11:0] Y_LO      = 12'(Y_POS);
    localparam logic [11:0] Y_HI      = 12'(Y_POS + GRID_SIZE * CELL_SIZE);
    localparam logic [11:0] CELL      = 12'(CELL_SIZE);
    localparam logic [3:0]  LAST      = 4'(GRID_SIZE - 1);
    localparam logic [3:0]  GS4       = 4'(GRID_SIZE);
    localparam logic [4:0]  MAX_SHIPS = 5'(MAX_SHIP_CELLS);

    localparam logic [1:0] C_EMPTY = 2'b00;
    localparam logic [1:0] C_SHIP  = 2'b01;
    localparam logic [1:0] C_MISS  = 2'b10;
    localparam logic [1:0] C_HIT   = 2'b11;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_CALC, S_READ, S_WRITE} state_t;

    state_t      state;
    logic        ml_s1, ml_s2, ml_s3, click;
    logic        clear_pend;
    logic [11:0] rem_x, rem_y;
    logic [3:0]  row, col, calc_cnt;
    logic        mode_q;
    logic [1:0]  old_val, new_val, wdata;
    logic        do_write, we, in_grid;
    logic [AW-1:0] waddr, raddr;
    logic [1:0]  mem [0:DEPTH-1];

    function automatic logic [AW-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return AW'({4'b0, r} * 8'(GRID_SIZE) + {4'b0, c});
    endfunction

    function automatic logic [1:0] shown(input logic [1:0] v);
`ifdef PLAYER_GRID_HIDE_SHIPS_EN
        return (v == C_SHIP) ? C_EMPTY : v;
`else
        return v;
`endif
    endfunction

    // Two-flop synchronizer for the mouse-domain button, then a registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            ml_s1 <= 1'b0;
            ml_s2 <= 1'b0;
            ml_s3 <= 1'b0;
            click <= 1'b0;
        end else begin
            ml_s1 <= mouse_left;
            ml_s2 <= ml_s1;
            ml_s3 <= ml_s2;
            click <= ml_s2 & ~ml_s3;
        end
    end

    assign in_grid = (mouse_x >= X_LO) && (mouse_x < X_HI) &&
                     (mouse_y >= Y_LO) && (mouse_y < Y_HI);

    // Next cell value for the latched click; do_write is low when the cell must not change
    always_comb begin
        new_val  = old_val;
        do_write = 1'b0;
        if (!mode_q) begin
            if (old_val == C_EMPTY && ship_cells < MAX_SHIPS) begin
                new_val  = C_SHIP;
                do_write = 1'b1;
            end else if (old_val == C_SHIP) begin
                new_val  = C_EMPTY;
                do_write = 1'b1;
            end
        end else begin
            if (old_val == C_SHIP) begin
                new_val  = C_HIT;
                do_write = 1'b1;
            end else if (old_val == C_EMPTY) begin
                new_val  = C_MISS;
                do_write = 1'b1;
            end
        end
    end

    assign waddr = cell_idx(row, col);
    assign raddr = cell_idx(grid_addr[7:4], grid_addr[3:0]);
    assign we    = (state == S_CLEAR) || (state == S_WRITE && do_write);
    assign wdata = (state == S_CLEAR) ? C_EMPTY : new_val;

    // Cell array: no reset, only the FSM writes it
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Control FSM: clear sweep, click latch, divider-free cell locate, read-modify-write
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            busy       <= 1'b1;
            row        <= '0;
            col        <= '0;
            calc_cnt   <= '0;
            rem_x      <= '0;
            rem_y      <= '0;
            mode_q     <= 1'b0;
            old_val    <= C_EMPTY;
            ship_cells <= '0;
            hit_cells  <= '0;
            clear_pend <= 1'b0;
        end else begin
            if (clear)
                clear_pend <= 1'b1;
            case (state)
                S_CLEAR: begin
                    if (col == LAST) begin
                        col <= '0;
                        if (row == LAST) begin
                            row   <= '0;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            row <= row + 4'd1;
                        end
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                S_IDLE: begin
                    if (clear_pend || clear) begin
                        clear_pend <= 1'b0;
                        ship_cells <= '0;
                        hit_cells  <= '0;
                        row        <= '0;
                        col        <= '0;
                        state      <= S_CLEAR;
                        busy       <= 1'b1;
                    end else if (click && in_grid) begin
                        rem_x    <= mouse_x - X_LO;
                        rem_y    <= mouse_y - Y_LO;
                        mode_q   <= mode;
                        row      <= '0;
                        col      <= '0;
                        calc_cnt <= '0;
                        state    <= S_CALC;
                        busy     <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (rem_x >= CELL) begin
                        rem_x <= rem_x - CELL;
                        col   <= col + 4'd1;
                    end
                    if (rem_y >= CELL) begin
                        rem_y <= rem_y - CELL;
                        row   <= row + 4'd1;
                    end
                    if (calc_cnt == LAST)
                        state <= S_READ;
                    else
                        calc_cnt <= calc_cnt + 4'd1;
                end
                S_READ: begin
                    old_val <= mem[waddr];
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (do_write) begin
                        if (!mode_q) begin
                            if (old_val == C_EMPTY)
                                ship_cells <= ship_cells + 5'd1;
                            else
                                ship_cells <= ship_cells - 5'd1;
                        end else if (old_val == C_SHIP) begin
                            hit_cells <= hit_cells + 5'd1;
                        end
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Game-over flag, one cycle behind the tallies
    always_ff @(posedge clk) begin
        if (rst)
            all_sunk <= 1'b0;
        else
            all_sunk <= (ship_cells != 5'd0) && (hit_cells == ship_cells);
    end

    // Registered lookup for the drawing stage; old value wins on a same-cycle write
    always_ff @(posedge clk) begin
        if (rst)
            grid_status <= C_EMPTY;
        else if (grid_addr[7:4] < GS4 && grid_addr[3:0] < GS4)
            grid_status <= shown(mem[raddr]);
        else
            grid_status <= C_EMPTY;
    end
endmodule

// File: tb/tb_player_grid_ctl.sv
// tb/tb_player_grid_ctl.sv - scoreboard bench for player_grid_ctl
module tb_player_grid_ctl;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mouse_x, mouse_y;
    logic        mouse_left, mode, clear;
    logic [7:0]  grid_addr;
    logic [1:0]  grid_status;
    logic        busy, all_sunk;
    logic [4:0]  ship_cells, hit_cells;

    player_grid_ctl dut (
        .clk(clk), .rst(rst), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .mouse_left(mouse_left), .mode(mode), .clear(clear), .grid_addr(grid_addr),
        .grid_status(grid_status), .busy(busy), .ship_cells(ship_cells),
        .hit_cells(hit_cells), .all_sunk(all_sunk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int model [10][10];
    int m_ship = 0;
    int m_hit  = 0;
    int exp_q [$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int vis(input int v);
`ifdef PLAYER_GRID_HIDE_SHIPS_EN
        return (v == 1) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic read_addr(input logic [7:0] a, input int exp);
        exp_q.push_back(exp);
        grid_addr = a;
        @(negedge clk);
        check($sformatf("status[%02h]", a), int'(grid_status), exp_q.pop_front());
    endtask

    task automatic read_cell(input int r, input int c);
        logic [7:0] a;
        a = {4'(r), 4'(c)};
        read_addr(a, vis(model[r][c]));
    endtask

    task automatic check_counts(input string tag);
        check({tag, " ship_cells"}, int'(ship_cells), m_ship);
        check({tag, " hit_cells"}, int'(hit_cells), m_hit);
        check({tag, " all_sunk"}, int'(all_sunk), (m_ship != 0 && m_hit == m_ship) ? 1 : 0);
    endtask

    task automatic model_clear();
        foreach (model[r, c]) model[r][c] = 0;
        m_ship = 0;
        m_hit  = 0;
    endtask

    // Busy is high at entry; counts samples until it drops, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_click(input int x, input int y, input logic md, output int busy_cycles);
        int w;
        mouse_x = 12'(x);
        mouse_y = 12'(y);
        mode = md;
        mouse_left = 1'b1;
        w = 0;
        busy_cycles = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (busy) count_busy(busy_cycles);
        mouse_left = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic click_and_check(input string tag, input int x, input int y, input logic md);
        int bc, r, c;
        bit inside_grid;
        inside_grid = (x >= 100 && x < 420 && y >= 100 && y < 420);
        do_click(x, y, md, bc);
        check({tag, " busy_cycles"}, bc, inside_grid ? 12 : 0);
        if (inside_grid) begin
            c = (x - 100) / 32;
            r = (y - 100) / 32;
            if (!md) begin
                if (model[r][c] == 0 && m_ship < 20) begin
                    model[r][c] = 1; m_ship++;
                end else if (model[r][c] == 1) begin
                    model[r][c] = 0; m_ship--;
                end
            end else begin
                if (model[r][c] == 1) begin
                    model[r][c] = 3; m_hit++;
                end else if (model[r][c] == 0) begin
                    model[r][c] = 2;
                end
            end
            read_cell(r, c);
        end
        check_counts(tag);
    endtask

    task automatic pulse_clear_and_check(input string tag);
        int n;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        count_busy(n);
        check({tag, " clear busy_cycles"}, n, 100);
        model_clear();
        repeat (2) @(negedge clk);
        check_counts(tag);
    endtask

    initial begin
        int n, w;
        rst = 1'b1; mouse_x = '0; mouse_y = '0; mouse_left = 1'b0;
        mode = 1'b0; clear = 1'b0; grid_addr = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 1);
        check("reset status", int'(grid_status), 0);
        check_counts("reset");

        // Reset sweep
        rst = 1'b0;
        count_busy(n);
        check("reset clear busy_cycles", n, 100);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                read_cell(r, c);
        read_addr(8'hAA, 0);
        read_addr(8'h0F, 0);
        check_counts("after sweep");

        // Place and remove
        click_and_check("place", 165, 100, 1'b0);
        click_and_check("remove", 165, 100, 1'b0);

        // Placement limit and out-of-grid pointers
        for (int r = 5; r < 7; r++)
            for (int c = 0; c < 10; c++)
                click_and_check("fill", 105 + 32 * c, 105 + 32 * r, 1'b0);
        click_and_check("over limit", 110, 110, 1'b0);
        click_and_check("left of grid", 99, 150, 1'b0);
        click_and_check("right of grid", 420, 150, 1'b0);
        read_addr(8'h5B, 0);
        pulse_clear_and_check("clear1");

        // Shooting
        click_and_check("ship 3,4", 233, 201, 1'b0);
        click_and_check("shoot hit", 240, 200, 1'b1);
        click_and_check("shoot miss", 110, 110, 1'b1);
        click_and_check("repeat hit", 240, 200, 1'b1);
        click_and_check("place on hit", 240, 200, 1'b0);
        click_and_check("ship 9,9", 415, 415, 1'b0);

        // Clear pulsed during CALC
        mouse_x = 12'd393; mouse_y = 12'd105; mode = 1'b0; mouse_left = 1'b1;
        w = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (busy && n < 1000) begin
            if (n == 2) clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            n++;
        end
        check("calc+clear update busy_cycles", n, 12);
        mouse_left = 1'b0;
        @(negedge clk);
        check("calc+clear clear started", int'(busy), 1);
        count_busy(n);
        check("calc+clear clear busy_cycles", n, 100);
        model_clear();
        repeat (2) @(negedge clk);
        check_counts("calc+clear");
        read_cell(0, 9);
        read_cell(3, 4);

        // Click during CLEAR is dropped
        mouse_x = 12'd105; mouse_y = 12'd105; mode = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            if (n == 5) mouse_left = 1'b1;
            if (n == 30) mouse_left = 1'b0;
            @(negedge clk);
            n++;
        end
        check("clear w/ click busy_cycles", n, 100);
        repeat (10) @(negedge clk);
        check("click during clear dropped busy", int'(busy), 0);
        read_cell(0, 0);
        check_counts("click during clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/player_grid_ctl.md
# player_grid_ctl

Game-state store for one 10x10 Warships board, clocked on the VGA clock and sitting directly upstream of the ship-drawing stage. It turns mouse left-clicks into per-cell state updates: placing ships in place mode, resolving shots in shoot mode. It answers the ship-drawing stage's per-pixel `grid_addr` lookups with a registered `grid_status`, which replaces the constant currently tied to that port. It also keeps ship and hit tallies for game-over detection.

## Interface
- `X_POS`, 100: x pixel of the grid's left edge; must match the ship-drawing stage.
- `Y_POS`, 100: y pixel of the grid's top edge.
- `CELL_SIZE`, 32: cell edge in pixels.
- `GRID_SIZE`, 10: cells per side, maximum 15.
- `MAX_SHIP_CELLS`, 20: placement limit.
- `clk`  in  1  the VGA clock; one clock only.
- `rst`  in  1  synchronous, active-high reset.
- `mouse_x`, `mouse_y`  in  12 each  pointer position; treated as quasi-static.
- `mouse_left`  in  1  left button from the mouse clock domain; asynchronous to `clk`.
- `mode`  in  1  0 = place, 1 = shoot.
- `clear`  in  1  single-cycle pulse that wipes the board.
- `grid_addr`  in  8  read address, encoded as {row[3:0], col[3:0]}.
- `grid_status`  out  2  state of the addressed cell, registered. Encoding: 00 empty, 01 ship, 10 miss, 11 hit.
- `busy`  out  1  an update or clear is in progress.
- `ship_cells`  out  5  number of cells currently holding a ship or a hit.
- `hit_cells`  out  5  number of cells in the hit state.
- `all_sunk`  out  1  asserted when `ship_cells != 0` and `hit_cells == ship_cells`.

## Operation
- **Click detection.** `mouse_left` passes through a two-flop synchronizer. A rising edge on the synchronized signal is a click.
- **Storage.** The cell array is GRID_SIZE² x 2-bit distributed RAM. It has no reset and is written only by the FSM.
- **FSM states:** CLEAR, IDLE, CALC, READ, WRITE.
- **CLEAR.**
  - Entered after `rst` and whenever a clear is pending and the FSM is in IDLE.
  - Sweeps row/col counters over all cells and writes 00, one cell per cycle. It then zeroes both counters and goes to IDLE.
- **IDLE.**
  - A pending clear takes priority over a click arriving in the same cycle; the click is dropped.
  - A click is ignored, with `busy` staying low, when it falls outside the grid: `mouse_x < X_POS`, `mouse_x >= X_POS + GRID_SIZE*CELL_SIZE`, or the same tests on y.
  - Otherwise the FSM latches `mouse_x - X_POS`, `mouse_y - Y_POS` and `mode`, then goes to CALC.
- **CALC.**
  - Runs exactly GRID_SIZE cycles of parallel repeated subtraction on the x and y remainders; no divider.
  - Each cycle, a remainder that is `>= CELL_SIZE` is reduced by CELL_SIZE and its col/row counter increments.
- **READ.** Fetches the old value of the target cell.
- **WRITE.** Writes the new value, updates the counters, returns to IDLE.
  - Place mode: empty becomes ship (`ship_cells` +1), only when `ship_cells < MAX_SHIP_CELLS`; otherwise no write. Ship becomes empty (`ship_cells` −1). Miss and hit are unchanged.
  - Shoot mode: ship becomes hit (`hit_cells` +1); empty becomes miss. Hit and miss are unchanged and there are no repeat counts.
- **Clear pulses.** A `clear` pulse in any state sets a pending flag, consumed on the next IDLE. Multiple pulses collapse into one.
- **Clicks while busy.** Clicks during CALC, READ, WRITE or CLEAR are dropped, not queued.
- **Read port.** `grid_status` is registered from `grid_addr` and is independent of the FSM.
  - An address with row or col `>= GRID_SIZE` returns 00.
  - On a same-cycle write to the addressed cell, the read returns the old value.

## Timing
- **Reset values:** `grid_status` 00, `busy` 1 (CLEAR starts immediately), `ship_cells` 0, `hit_cells` 0, `all_sunk` 0, FSM in CLEAR.
- **Reset mid-operation:** `rst` in any state aborts the state and restarts CLEAR; counters return to 0.
- **Read latency:** 1 cycle from `grid_addr` to `grid_status`.
- **CLEAR:** `busy` high for GRID_SIZE² cycles, i.e. 100 at the defaults.
- **Click edge:** detected 3 cycles after `mouse_left` rises, counting 2 synchronizer stages plus the edge register.
- **Update:** `busy` rises the cycle after the edge is detected and stays high GRID_SIZE+2 cycles (CALC, READ, WRITE).
  - The new cell value is readable on `grid_status` 2 cycles after WRITE.
  - Counters update on the WRITE edge.
- **`all_sunk`:** registered, valid 1 cycle after the counters change.

## Configuration
- **`PLAYER_GRID_HIDE_SHIPS_EN` defined:** `grid_status` reports ship (01) as empty (00); this is used for the opponent's board. Miss, hit, the counters and all internal behaviour are unchanged.
- **Not defined:** `grid_status` returns the stored value.

## Test plan
- **Reset sweep.** After `rst`, `busy` stays high for 100 cycles. Then read all addresses: every cell returns 00 and both counters are 0.
- **Place and remove.** Mode 0, pointer (165,100), click: cell {row 0, col 2} reads 01 and `ship_cells` = 1, with `busy` high exactly 12 cycles. Click again: the cell reads 00 and `ship_cells` = 0.
- **Placement limit.** Place 20 ships, then click an empty cell: no change and `ship_cells` stays 20. Pointer at (99,150) or (420,150): `busy` never rises.
- **Shooting.**
  - Ship at {3,4}, mode 1: a click at (240,200) gives 11, `hit_cells` = 1, and `all_sunk` = 1 when it is the only ship.
  - A click on an empty cell gives 10.
  - A repeat click on the hit cell leaves `hit_cells` at 1.
- **Clear and busy interplay.**
  - Pulse `clear` during CALC: the update completes, then a 100-cycle CLEAR runs and all counters zero.
  - A click during CLEAR is dropped.
- **Macro.** With `PLAYER_GRID_HIDE_SHIPS_EN` defined, a ship cell reads 00 and a hit cell reads 11.
